// File: rtl/assert_sched_pkg.sv
// Shared types for the assert_sched error-report scheduler: FSM state encoding
// and the channel-index width helper.
package assert_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALT   = 2'd3
    } sched_state_t;

    // Index width for an n-entry channel set, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/assert_rr_arb.sv
// N-way round-robin arbiter: picks the first requesting channel after the
// last granted index, wrapping at N. Purely combinational.
module assert_rr_arb
    import assert_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    int pos;

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        for (int off = N; off >= 1; off--) begin
            pos = (int'(last) + off) % N;
            if (en && req[pos[IW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/assert_sched.sv
// Shares one error-report channel among N test/pattern comparators with sticky
// flags, round-robin draining, error counting and a halt limit.
// Optional per-channel mismatch timestamps: ASSERT_SCHED_TIMESTAMP_EN.
module assert_sched
    import assert_sched_pkg::*;
#(
    parameter int N      = 4,
    parameter int CNT_W  = 8,
    parameter int TS_W   = 16,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_W-1:0]     max_err,
    input  logic [N-1:0]         chk_en,
    input  logic [N-1:0]         test,
    input  logic [N-1:0]         pat,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [$clog2(N)-1:0] rpt_chan,
    output logic [TS_W-1:0]      rpt_time,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 busy,
    output logic                 halted,
    output logic                 overrun
);

    localparam int IW    = idx_w(N);
    localparam int SUM_W = CNT_W + 5;
    localparam logic [7:0] SETTLE_LD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    sched_state_t     state_q, state_d;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    logic [N-1:0]     pend_q, pend_d, mis, clr;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0] err_sum;
    logic [IW-1:0]    last_q, last_d, gnt_idx;
    logic             rpt_valid_q, rpt_valid_d;
    logic [IW-1:0]    rpt_chan_q, rpt_chan_d;
    logic             gnt_valid, sample, arb_en;

    // start/stop cycles neither sample nor grant, so a cleared flag never leaks out.
    assign sample = (state_q == ST_RUN) && !start && !stop;
    assign mis    = sample ? (chk_en & (test ^ pat)) : '0;
    assign arb_en = (!rpt_valid_q || rpt_ready) && !start && !stop;
    assign clr    = gnt_valid ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    assert_rr_arb #(.N(N), .IW(IW)) u_arb (
        .req       (pend_q),
        .last      (last_q),
        .en        (arb_en),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            pend_q       <= '0;
            overrun_q    <= 1'b0;
            err_cnt_q    <= '0;
            last_q       <= IW'(N - 1);
            rpt_valid_q  <= 1'b0;
            rpt_chan_q   <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            pend_q       <= pend_d;
            overrun_q    <= overrun_d;
            err_cnt_q    <= err_cnt_d;
            last_q       <= last_d;
            rpt_valid_q  <= rpt_valid_d;
            rpt_chan_q   <= rpt_chan_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        if (start) begin
            state_d      = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
            settle_cnt_d = SETTLE_LD;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q == 8'd0) state_d = ST_RUN;
                    else                      settle_cnt_d = settle_cnt_q - 8'd1;
                end
                ST_RUN: begin
                    if ((max_err != '0) && (err_cnt_d >= max_err)) state_d = ST_HALT;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        err_sum = SUM_W'(err_cnt_q);
        for (int i = 0; i < N; i++) err_sum = err_sum + SUM_W'(mis[i]);
    end

    // A new mismatch on the channel being granted re-arms it without overrun.
    always_comb begin
        err_cnt_d = err_cnt_q;
        overrun_d = overrun_q;
        if (start) begin
            err_cnt_d = '0;
            overrun_d = 1'b0;
        end else begin
            err_cnt_d = (err_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : err_sum[CNT_W-1:0];
            if (|(mis & pend_q & ~clr)) overrun_d = 1'b1;
        end
        pend_d = (start || stop) ? '0 : ((pend_q & ~clr) | mis);
    end

    always_comb begin
        rpt_valid_d = rpt_valid_q;
        rpt_chan_d  = rpt_chan_q;
        last_d      = last_q;
        if (gnt_valid) begin
            rpt_valid_d = 1'b1;
            rpt_chan_d  = gnt_idx;
            last_d      = gnt_idx;
        end else if (rpt_valid_q && rpt_ready) begin
            rpt_valid_d = 1'b0;
        end
    end

    always_comb begin
        busy      = (state_q == ST_SETTLE) || (state_q == ST_RUN);
        halted    = (state_q == ST_HALT);
        rpt_valid = rpt_valid_q;
        rpt_chan  = rpt_chan_q;
        err_cnt   = err_cnt_q;
        overrun   = overrun_q;
    end

`ifdef ASSERT_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d, rpt_time_q, rpt_time_d;
    logic [TS_W-1:0] ts_ch_q [N];
    logic [TS_W-1:0] ts_ch_d [N];
    logic [N-1:0]    cap;

    // Capture only when the flag is not still pending after this cycle's grant.
    assign cap        = mis & ~(pend_q & ~clr);
    assign ts_d       = start ? '0 : ts_q + 1'b1;
    assign rpt_time_d = gnt_valid ? ts_ch_q[gnt_idx] : rpt_time_q;
    assign rpt_time   = rpt_time_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            rpt_time_q <= '0;
        end else begin
            ts_q       <= ts_d;
            rpt_time_q <= rpt_time_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ts
        assign ts_ch_d[gi] = cap[gi] ? ts_q : ts_ch_q[gi];
        always_ff @(posedge clk) begin
            if (rst) ts_ch_q[gi] <= '0;
            else     ts_ch_q[gi] <= ts_ch_d[gi];
        end
    end
`else
    assign rpt_time = '0;
`endif

endmodule

// File: tb/tb_assert_sched.sv
// Directed bench for assert_sched: report scoreboard, stall stability, overrun,
// error-limit halt and stop behaviour.
module tb_assert_sched;

    localparam int N = 4, CNT_W = 8, TS_W = 16, SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst, start, stop, rpt_ready;
    logic [CNT_W-1:0] max_err;
    logic [N-1:0]     chk_en, test, pat;
    logic             rpt_valid, busy, halted, overrun;
    logic [1:0]       rpt_chan;
    logic [TS_W-1:0]  rpt_time;
    logic [CNT_W-1:0] err_cnt;

    assert_sched #(.N(N), .CNT_W(CNT_W), .TS_W(TS_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .max_err(max_err),
        .chk_en(chk_en), .test(test), .pat(pat), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_chan(rpt_chan), .rpt_time(rpt_time),
        .err_cnt(err_cnt), .busy(busy), .halted(halted), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int chan; int ts; } rpt_t;
    rpt_t sb[$];
    int nvec = 0, nerr = 0, cyc = 0, s_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Timestamp of a mismatch sampled at edge k, counted from the start edge.
    function automatic int exp_ts(input int k);
`ifdef ASSERT_SCHED_TIMESTAMP_EN
        return (k - s_edge - 1) & ((1 << TS_W) - 1);
`else
        return 0;
`endif
    endfunction

    task automatic push(input int ch, input int k);
        rpt_t r;
        r.chan = ch;
        r.ts   = exp_ts(k);
        sb.push_back(r);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start  = 1'b0;
        s_edge = cyc;
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        rpt_t r;
        logic hold;
        int   hchan, hts;
        hold = 1'b0; hchan = 0; hts = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", rpt_valid, 1);
                    chk("hold_chan", rpt_chan, hchan);
                    chk("hold_time", rpt_time, hts);
                end
                if (rpt_valid && rpt_ready) begin
                    chk("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        r = sb.pop_front();
                        chk("rpt_chan", rpt_chan, r.chan);
                        chk("rpt_time", rpt_time, r.ts);
                    end
                end
                hold  = rpt_valid && !rpt_ready;
                hchan = int'(rpt_chan);
                hts   = int'(rpt_time);
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; stop = 1'b0; rpt_ready = 1'b1;
        max_err = '0; chk_en = '1; test = '0; pat = '0;
        tick(3);
        chk("rst_valid", rpt_valid, 0);
        chk("rst_chan", rpt_chan, 0);
        chk("rst_time", rpt_time, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick(1);

        // Mismatch during SETTLE is ignored.
        pulse_start();
        chk("settle_busy", busy, 1);
        test = 4'b0010;
        tick(2);
        test = '0;
        tick(1);
        chk("settle_err", err_cnt, 0);
        chk("settle_valid", rpt_valid, 0);

        // Three simultaneous mismatches drained in order 0,1,3 after a stall.
        rpt_ready = 1'b0;
        test = 4'b1011;
        tick(1);
        k = cyc;
        push(0, k); push(1, k); push(3, k);
        test = '0;
        chk("multi_err", err_cnt, 3);
        tick(1);
        chk("multi_valid", rpt_valid, 1);
        chk("multi_first", rpt_chan, 0);
        tick(4);
        rpt_ready = 1'b1;
        tick(3);
        chk("multi_drained", rpt_valid, 0);
        chk("multi_sb_empty", sb.size(), 0);

        // Single one-cycle mismatch on channel 2: report for exactly one cycle.
        test = 4'b0100;
        tick(1);
        push(2, cyc);
        test = '0;
        chk("ch2_err", err_cnt, 4);
        chk("ch2_not_yet", rpt_valid, 0);
        tick(1);
        chk("ch2_valid", rpt_valid, 1);
        chk("ch2_chan", rpt_chan, 2);
        tick(1);
        chk("ch2_one_cycle", rpt_valid, 0);

        // Channel 0 hits twice while the slot is stalled: overrun, one report.
        rpt_ready = 1'b0;
        test = 4'b0010;
        tick(1);
        push(1, cyc);
        test = '0;
        tick(1);
        test = 4'b0001;
        tick(1);
        push(0, cyc);
        tick(1);
        test = '0;
        chk("ovr_flag", overrun, 1);
        chk("ovr_err", err_cnt, 7);
        chk("ovr_slot", rpt_chan, 1);
        rpt_ready = 1'b1;
        tick(3);
        chk("ovr_drained", rpt_valid, 0);
        chk("ovr_sb_empty", sb.size(), 0);

        // Error limit 4 with two persistent mismatches halts on the 2nd cycle.
        max_err = 8'd4;
        pulse_start();
        tick(2);
        chk("lim_err0", err_cnt, 0);
        chk("lim_busy", busy, 1);
        chk("lim_ovr_clr", overrun, 0);
        test = 4'b0110;
        tick(1);
        push(1, cyc); push(2, cyc);
        chk("lim_err2", err_cnt, 2);
        chk("lim_not_halt", halted, 0);
        tick(1);
        push(1, cyc);
        chk("lim_err4", err_cnt, 4);
        chk("lim_halted", halted, 1);
        chk("lim_idle_busy", busy, 0);
        tick(2);
        chk("lim_err_hold", err_cnt, 4);
        test = '0;
        tick(2);
        chk("lim_drained", rpt_valid, 0);
        chk("lim_sb_empty", sb.size(), 0);
        max_err = '0;
        pulse_start();
        chk("restart_err", err_cnt, 0);
        chk("restart_busy", busy, 1);
        chk("restart_halted", halted, 0);
        tick(2);

        // stop while a report is stalled: pending cleared, report still delivered.
        rpt_ready = 1'b0;
        test = 4'b1001;
        tick(1);
        push(3, cyc);
        test = '0;
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_valid", rpt_valid, 1);
        chk("stop_chan", rpt_chan, 3);
        rpt_ready = 1'b1;
        tick(2);
        chk("stop_no_pend", rpt_valid, 0);
        chk("stop_sb_empty", sb.size(), 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
